mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between the instruction-fetch requester (I) and the data requester (D).

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one stalled-latency memory port between instruction fetch (I) and data (D) requesters.
// D has priority; an I starvation guard forces an I grant after STARVE_LIMIT consecutive D grants.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_rd,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 d_ack,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    input  logic                 mem_ack,
    output logic [1:0]           err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GNT_I   = 3'd1,
        GNT_DR  = 3'd2,
        GNT_DW  = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 i_ready_q, i_ready_d;
    logic                 d_ready_q, d_ready_d;
    logic                 d_ack_q, d_ack_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [1:0]           err_q, err_d;
    logic                 done_c;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            d_ack_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            d_ack_q      <= d_ack_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            err_q        <= err_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        d_ack_d      = 1'b0;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        err_d        = err_q;
        // Completion level is stale-prone on the first grant cycle, so require wait_cnt >= 1.
        done_c       = (wait_cnt_q != '0) &&
                       ((state_q == GNT_DW) ? mem_ack : mem_ready);

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (d_rd && d_wr) begin
                    err_d[0] = 1'b1;
                end
                if (i_req && (starve_cnt_q == SW'(STARVE_LIMIT))) begin
                    state_d      = GNT_I;
                    mem_read_d   = 1'b1;
                    mem_addr_d   = i_addr;
                    starve_cnt_d = '0;
                end else if (d_wr || d_rd) begin
                    state_d     = d_wr ? GNT_DW : GNT_DR;
                    mem_write_d = d_wr;
                    mem_read_d  = !d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_req && (starve_cnt_q < SW'(STARVE_LIMIT))) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end else if (i_req) begin
                    state_d      = GNT_I;
                    mem_read_d   = 1'b1;
                    mem_addr_d   = i_addr;
                    starve_cnt_d = '0;
                end
            end
            GNT_I, GNT_DR, GNT_DW: begin
                if (done_c) begin
                    state_d     = RELEASE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    wait_cnt_d  = '0;
                    i_ready_d   = (state_q == GNT_I);
                    d_ready_d   = (state_q == GNT_DR);
                    d_ack_d     = (state_q == GNT_DW);
                    if (state_q == GNT_I) begin
                        i_rdata_d = mem_rdata;
                    end
                    if (state_q == GNT_DR) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    if (wait_cnt_q < WW'(TIMEOUT)) begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                    // Timeout only flags; the grant keeps waiting.
                    if (wait_cnt_d == WW'(TIMEOUT)) begin
                        err_d[1] = 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_ack     = d_ack_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4-cycle-stall memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_ready;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        d_ack;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_ack;
    logic [1:0]  err;

    int n_vec;
    int n_err;
    int i_cnt;
    int d_cnt;
    int i0;
    int d0;
    int cyc;
    logic tie_low;

    mem_port_arbiter #(
        .WORD_SIZE   (16),
        .STARVE_LIMIT(3),
        .TIMEOUT     (64)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .d_ack    (d_ack),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_ack  (mem_ack),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: done level rises once the strobe has been high for 4 cycles
    logic [15:0] mem [0:255];
    logic [1:0]  stall;
    always @(posedge clk) begin
        if (!reset_n) begin
            mem[8'h23] <= 16'h6000;
            mem[8'h10] <= 16'hA5A5;
        end else if (mem_write && mem_ack) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        if (!(mem_read || mem_write)) stall <= 2'd0;
        else if (stall != 2'd3)       stall <= stall + 2'd1;
    end
    assign mem_rdata = mem[mem_addr[7:0]];
    assign mem_ready = mem_read && !tie_low && (stall == 2'd3);
    assign mem_ack   = mem_write && (stall == 2'd3);

    always @(posedge clk) begin
        if (i_ready) i_cnt++;
        if (d_ready) d_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // sel: 0=i_ready 1=d_ready 2=d_ack; returns negedges elapsed (limit on timeout)
    task automatic wait_pulse(input int sel, input int limit, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            tick();
            n++;
            hit = (sel == 0) ? i_ready : (sel == 1) ? d_ready : d_ack;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; i_cnt = 0; d_cnt = 0;
        reset_n = 1'b0; tie_low = 1'b0; stall = 2'd0;
        i_req = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        tick(); tick();
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pulses", 32'({i_ready, d_ready, d_ack}), 32'd0);
        reset_n = 1'b1;
        tick();

        // I read of 0x0023
        i_req = 1'b1; i_addr = 16'h0023;
        tick();
        chk("i_strobe", 32'(mem_read), 32'd1);
        chk("i_addr", 32'(mem_addr), 32'h0023);
        wait_pulse(0, 20, cyc);
        chk("i_latency", 32'(cyc), 32'd4);
        chk("i_rdata", 32'(i_rdata), 32'h6000);
        i_req = 1'b0;
        tick();
        chk("i_pulse_one", 32'(i_ready), 32'd0);
        chk("i_rdata_hold", 32'(i_rdata), 32'h6000);
        chk("i_strobe_off", 32'(mem_read), 32'd0);

        // D write then D read of 0x0001
        d_wr = 1'b1; d_addr = 16'h0001; d_wdata = 16'hBEEF;
        tick();
        chk("dw_strobe", 32'({mem_write, mem_read}), 32'b10);
        chk("dw_wdata", 32'(mem_wdata), 32'hBEEF);
        wait_pulse(2, 20, cyc);
        chk("dw_latency", 32'(cyc), 32'd4);
        d_wr = 1'b0; d_rd = 1'b1;
        wait_pulse(1, 20, cyc);
        chk("dr_latency", 32'(cyc), 32'd6);
        chk("dr_rdata", 32'(d_rdata), 32'hBEEF);
        d_rd = 1'b0;
        tick(); tick();

        // Simultaneous I and D: D first
        i0 = i_cnt; d0 = d_cnt;
        i_req = 1'b1; i_addr = 16'h0023; d_rd = 1'b1; d_addr = 16'h0001;
        wait_pulse(1, 20, cyc);
        chk("both_d_first", 32'(cyc), 32'd5);
        chk("both_i_waits", 32'(i_ready), 32'd0);
        d_rd = 1'b0;
        wait_pulse(0, 20, cyc);
        chk("both_i_second", 32'(cyc), 32'd6);
        i_req = 1'b0;
        tick(); tick();
        chk("both_i_count", 32'(i_cnt - i0), 32'd1);
        chk("both_d_count", 32'(d_cnt - d0), 32'd1);

        // Starvation guard: I wins after three D grants
        i0 = i_cnt; d0 = d_cnt;
        i_req = 1'b1; d_rd = 1'b1;
        wait_pulse(0, 60, cyc);
        chk("starve_latency", 32'(cyc), 32'd23);
        chk("starve_d_grants", 32'(d_cnt - d0), 32'd3);
        i_req = 1'b0; d_rd = 1'b0;
        tick(); tick();
        chk("starve_i_count", 32'(i_cnt - i0), 32'd1);

        // d_rd & d_wr together: write wins, err[0] sticky
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0002; d_wdata = 16'h1234;
        tick();
        chk("conflict_strobe", 32'({mem_write, mem_read}), 32'b10);
        chk("conflict_err", 32'(err), 32'b01);
        wait_pulse(2, 20, cyc);
        chk("conflict_ack", 32'(cyc), 32'd4);
        d_rd = 1'b0; d_wr = 1'b0;
        tick(); tick();
        chk("conflict_sticky", 32'(err), 32'b01);

        // Reset mid-grant
        d_rd = 1'b1; d_addr = 16'h0002;
        tick(); tick();
        chk("pre_rst_strobe", 32'(mem_read), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        chk("mid_rst_pulses", 32'({i_ready, d_ready, d_ack}), 32'd0);
        reset_n = 1'b1; d_rd = 1'b0;
        i_req = 1'b1; i_addr = 16'h0023;
        wait_pulse(0, 20, cyc);
        chk("post_rst_latency", 32'(cyc), 32'd5);
        chk("post_rst_rdata", 32'(i_rdata), 32'h6000);
        i_req = 1'b0;
        tick(); tick();

        // mem_ready tied low: timeout after 64 grant cycles, grant persists
        tie_low = 1'b1; i_req = 1'b1; i_addr = 16'h0010;
        repeat (64) tick();
        chk("to_before_err", 32'(err), 32'b00);
        chk("to_before_strobe", 32'(mem_read), 32'd1);
        tick();
        chk("to_err", 32'(err), 32'b10);
        chk("to_strobe", 32'(mem_read), 32'd1);
        repeat (5) tick();
        chk("to_still_waiting", 32'({mem_read, i_ready}), 32'b10);
        tie_low = 1'b0;
        wait_pulse(0, 10, cyc);
        chk("to_late_done", 32'(cyc), 32'd1);
        chk("to_rdata", 32'(i_rdata), 32'hA5A5);
        chk("to_err_sticky", 32'(err), 32'b10);
        i_req = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
